// File: rtl/mem_pkg.sv
// Shared types for the data-memory path: arbiter state, grant owner
// and the request bundle used by requesters and the data_mem wrapper.
package mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        GNT_C = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      funct3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: 2-way round-robin picker. Bit 0 = core (C), bit 1 = DMA (D).
// Ports: i_valid[1:0] requests, i_last previous owner, o_gnt one-hot grant.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] i_valid,
    input  gnt_t       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_valid)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // on a tie the requester that did not go last wins
            2'b11:   o_gnt = (i_last == GNT_D) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (c_*)
// and a DMA/loader port (d_*). Valid/ready requests, round-robin grant,
// bounded D burst lock (d_lock), registered load responses one cycle later.
// Ports: clk, rst_n (async low); c_/d_ valid, ready, we, addr, wdata, funct3,
// rvalid, rdata; d_lock; mem_wr_en, mem_addr, mem_wdata, mem_funct3, mem_rdata.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [DATA_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_funct3,
    input  logic                  d_lock,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LIMIT   = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam bit            LOCK_EN = (MAX_BURST > 1);

    arb_state_t            r_state;
    gnt_t                  r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_c_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_c_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic [1:0] w_pick;
    logic       w_gnt_c;
    logic       w_gnt_d;

    rr_pick2 u_pick (
        .i_valid ({d_valid, c_valid}),
        .i_last  (r_last),
        .o_gnt   (w_pick)
    );

    always_comb begin
        w_gnt_c = 1'b0;
        w_gnt_d = 1'b0;
        if (r_state == ARB) begin
            w_gnt_c = w_pick[0];
            w_gnt_d = w_pick[1];
        end else begin
            // D owns the memory; C stalls until the burst ends
            w_gnt_d = d_valid && d_lock && (r_cnt < LIMIT);
        end
    end

    always_comb begin
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = 3'b000;
        if (w_gnt_c) begin
            mem_wr_en  = c_we;
            mem_addr   = c_addr;
            mem_wdata  = c_wdata;
            mem_funct3 = c_funct3;
        end else if (w_gnt_d) begin
            mem_wr_en  = d_we;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            mem_funct3 = d_funct3;
        end
    end

    assign c_ready  = w_gnt_c;
    assign d_ready  = w_gnt_d;
    assign c_rvalid = r_c_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rdata  = r_d_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_last  <= GNT_D;
            r_cnt   <= '0;
        end else if (r_state == ARB) begin
            if (w_gnt_c) begin
                r_last <= GNT_C;
            end
            if (w_gnt_d) begin
                r_last <= GNT_D;
                if (d_lock && LOCK_EN) begin
                    r_state <= BURST;
                    r_cnt   <= ONE;
                end
            end
        end else begin
            if (w_gnt_d) begin
                r_cnt <= r_cnt + ONE;
            end else begin
                // lock dropped, D idle or limit reached: hand back
                r_state <= ARB;
                r_cnt   <= '0;
                r_last  <= GNT_D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_gnt_c && !c_we;
            r_d_rvalid <= w_gnt_d && !d_we;
            if (w_gnt_c && !c_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (w_gnt_d && !d_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (MAX_BURST=4) with a behavioural
// data memory and a per-requester response scoreboard.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_valid, c_ready, c_we, c_rvalid;
    logic [DW-1:0] c_addr, c_wdata, c_rdata;
    logic [2:0]    c_funct3;
    logic          d_valid, d_ready, d_we, d_lock, d_rvalid;
    logic [DW-1:0] d_addr, d_wdata, d_rdata;
    logic [2:0]    d_funct3;
    logic          mem_wr_en;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]    mem_funct3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_c_q[$];
    logic [DW-1:0] exp_d_q[$];
    logic [DW-1:0] mon_e;

    logic [DW-1:0] tb_mem  [0:255];
    logic          wr_seen [0:255] = '{default: 1'b0};
    logic [DW-1:0] ref_mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_lock(d_lock), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [7:0] a);
        return {a ^ 8'h5A, 8'hC3, ~a, a};
    endfunction

    assign mem_rdata = wr_seen[mem_addr[9:2]] ? tb_mem[mem_addr[9:2]]
                                              : pat(mem_addr[9:2]);

    always @(posedge clk) begin
        if (mem_wr_en) begin
            tb_mem[mem_addr[9:2]]  <= mem_wdata;
            wr_seen[mem_addr[9:2]] <= 1'b1;
        end
    end

    // response scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_rvalid || exp_c_q.size() != 0) begin
                n_cmp++;
                if (!c_rvalid) begin
                    n_bad++;
                    $display("FAIL c_resp: c_rvalid=0 required 1");
                    void'(exp_c_q.pop_front());
                end else if (exp_c_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL c_resp: c_rvalid=1 required 0");
                end else begin
                    mon_e = exp_c_q.pop_front();
                    if (c_rdata !== mon_e) begin
                        n_bad++;
                        $display("FAIL c_rdata: got %h required %h", c_rdata, mon_e);
                    end
                end
            end
            if (d_rvalid || exp_d_q.size() != 0) begin
                n_cmp++;
                if (!d_rvalid) begin
                    n_bad++;
                    $display("FAIL d_resp: d_rvalid=0 required 1");
                    void'(exp_d_q.pop_front());
                end else if (exp_d_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL d_resp: d_rvalid=1 required 0");
                end else begin
                    mon_e = exp_d_q.pop_front();
                    if (d_rdata !== mon_e) begin
                        n_bad++;
                        $display("FAIL d_rdata: got %h required %h", d_rdata, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive_c(input logic v, input logic we,
                           input logic [DW-1:0] a, input logic [DW-1:0] wd);
        c_valid  = v;
        c_we     = we;
        c_addr   = a;
        c_wdata  = wd;
        c_funct3 = 3'b010;
    endtask

    task automatic drive_d(input logic v, input logic we, input logic lk,
                           input logic [DW-1:0] a, input logic [DW-1:0] wd);
        d_valid  = v;
        d_we     = we;
        d_lock   = lk;
        d_addr   = a;
        d_wdata  = wd;
        d_funct3 = 3'b100;
    endtask

    // advance past the edge and record what the expected grants did
    task automatic step(input logic ec, input logic ed);
        @(posedge clk);
        #1;
        if (ec) begin
            if (c_we) ref_mem[c_addr[9:2]] = c_wdata;
            else exp_c_q.push_back(ref_mem[c_addr[9:2]]);
        end
        if (ed) begin
            if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
            else exp_d_q.push_back(ref_mem[d_addr[9:2]]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_c(0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({c_rvalid, d_rvalid, mem_wr_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_flags: got %b required 000",
                     {c_rvalid, d_rvalid, mem_wr_en});
        end
        rst_n = 1'b1;
        drive_c(1, 0, 32'h10, 0);
        drive_d(1, 0, 0, 32'h20, 0);
        @(negedge clk);
        n_cmp++;
        if ({c_ready, d_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_tie1: rdy c,d=%b required 10", {c_ready, d_ready});
        end
        step(1, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({c_rvalid, d_rvalid, mem_wr_en} !== 3'b000 ||
            c_rdata !== '0 || d_rdata !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: rv=%b wr=%b crd=%h drd=%h required 0",
                     {c_rvalid, d_rvalid}, mem_wr_en, c_rdata, d_rdata);
        end
        exp_c_q.delete();
        exp_d_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({c_ready, d_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_tie2: rdy c,d=%b required 10", {c_ready, d_ready});
        end
        step(1, 0);
        drive_c(0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({c_ready, d_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_d: rdy c,d=%b required 01", {c_ready, d_ready});
        end
        step(0, 1);
        drive_d(0, 0, 0, 0, 0);
        step(0, 0);
    endtask

    task automatic test_c_alone();
        drive_c(1, 1, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if (c_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 32'h100 ||
            mem_wdata !== 32'hDEADBEEF || mem_funct3 !== 3'b010) begin
            n_bad++;
            $display("FAIL c_store: rdy=%b wr=%b a=%h wd=%h f3=%b required 1 1 100 deadbeef 010",
                     c_ready, mem_wr_en, mem_addr, mem_wdata, mem_funct3);
        end
        step(1, 0);
        drive_c(1, 0, 32'h100, 0);
        @(negedge clk);
        n_cmp++;
        if (c_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL c_load: rdy=%b wr=%b required 1 0", c_ready, mem_wr_en);
        end
        step(1, 0);
        drive_c(0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL c_resp1: rv=%b rd=%h drv=%b required 1 deadbeef 0",
                     c_rvalid, c_rdata, d_rvalid);
        end
        step(0, 0);
        @(negedge clk);
        n_cmp++;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF || mem_addr !== '0) begin
            n_bad++;
            $display("FAIL c_hold: rv=%b rd=%h a=%h required 0 deadbeef 0",
                     c_rvalid, c_rdata, mem_addr);
        end
        step(0, 0);
    endtask

    task automatic test_alternate();
        int ci = 0;
        int di = 0;
        int gc = 0;
        int gd = 0;
        logic ec, ed;
        for (int i = 0; i < 6; i++) begin
            drive_c(1, 0, 32'h200 + 32'(4 * ci), 0);
            drive_d(1, 0, 0, 32'h300 + 32'(4 * di), 0);
            ed = (i % 2 == 0);
            ec = !ed;
            @(negedge clk);
            if (c_ready === 1'b1) gc++;
            if (d_ready === 1'b1) gd++;
            n_cmp++;
            if ({c_ready, d_ready} !== {ec, ed}) begin
                n_bad++;
                $display("FAIL alt[%0d]: rdy c,d=%b required %b",
                         i, {c_ready, d_ready}, {ec, ed});
            end
            step(ec, ed);
            if (ec) ci++;
            if (ed) di++;
        end
        n_cmp++;
        if (gc != 3 || gd != 3) begin
            n_bad++;
            $display("FAIL alt_count: c=%0d d=%0d required 3 3", gc, gd);
        end
        drive_c(0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0);
        step(0, 0);
    endtask

    task automatic test_burst();
        bit cv [0:8];
        bit dv [0:8];
        bit ec [0:8];
        bit ed [0:8];
        int dk = 0;
        cv = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
        dv = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        ec = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        ed = '{1, 1, 1, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            drive_c(cv[i], 0, 32'h600, 0);
            drive_d(dv[i], 0, dv[i], 32'h400 + 32'(4 * dk), 0);
            @(negedge clk);
            n_cmp++;
            if ({c_ready, d_ready} !== {ec[i], ed[i]}) begin
                n_bad++;
                $display("FAIL burst[%0d]: rdy c,d=%b required %b",
                         i, {c_ready, d_ready}, {ec[i], ed[i]});
            end
            step(ec[i], ed[i]);
            if (ed[i]) dk++;
        end
        drive_c(0, 0, 0, 0);
        step(0, 0);
    endtask

    task automatic test_lock_release();
        bit cv [0:10];
        bit dv [0:10];
        bit dl [0:10];
        bit ec [0:10];
        bit ed [0:10];
        int dk = 0;
        cv = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        dv = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        dl = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        ec = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        ed = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            drive_c(cv[i], 0, 32'h640, 0);
            drive_d(dv[i], 0, dl[i], 32'h480 + 32'(4 * dk), 0);
            @(negedge clk);
            n_cmp++;
            if ({c_ready, d_ready} !== {ec[i], ed[i]}) begin
                n_bad++;
                $display("FAIL lockrel[%0d]: rdy c,d=%b required %b",
                         i, {c_ready, d_ready}, {ec[i], ed[i]});
            end
            step(ec[i], ed[i]);
            if (ed[i]) dk++;
        end
        step(0, 0);
    endtask

    task automatic test_store_d();
        drive_d(1, 1, 0, 32'h500, 32'h12345678);
        @(negedge clk);
        n_cmp++;
        if (d_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 32'h500 ||
            mem_funct3 !== 3'b100) begin
            n_bad++;
            $display("FAIL d_store: rdy=%b wr=%b a=%h f3=%b required 1 1 500 100",
                     d_ready, mem_wr_en, mem_addr, mem_funct3);
        end
        step(0, 1);
        drive_d(1, 0, 0, 32'h500, 0);
        @(negedge clk);
        n_cmp++;
        if (d_rvalid !== 1'b0 || d_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL d_after_store: rv=%b rdy=%b wr=%b required 0 1 0",
                     d_rvalid, d_ready, mem_wr_en);
        end
        step(0, 1);
        drive_d(1, 0, 1, 32'h504, 0);
        @(negedge clk);
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL d_lock_go: rdy=%b required 1", d_ready);
        end
        step(0, 1);
        drive_c(1, 0, 32'h660, 0);
        rst_n = 1'b0;
        #1;
        exp_c_q.delete();
        exp_d_q.delete();
        n_cmp++;
        if ({c_ready, d_ready, d_rvalid} !== 3'b100) begin
            n_bad++;
            $display("FAIL rst_burst: rdy c,d=%b drv=%b required 10 0",
                     {c_ready, d_ready}, d_rvalid);
        end
        @(posedge clk);
        #1;
        drive_c(0, 0, 0, 0);
        drive_d(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0);
        step(0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
        test_reset();
        test_c_alone();
        test_alternate();
        test_burst();
        test_lock_release();
        test_store_d();
        n_cmp++;
        if (exp_c_q.size() != 0 || exp_d_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending c=%0d d=%0d required 0 0",
                     exp_c_q.size(), exp_d_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
